// File: rtl/instr_regbank_pkg.sv
// rtl/instr_regbank_pkg.sv - shared constants and helpers for the instruction register bank
package instr_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Operates on the widest supported word; callers truncate to their data width.
  function automatic logic [63:0] strb_merge(input logic [63:0] cur,
                                             input logic [63:0] wdata,
                                             input logic [7:0]  strb);
    logic [63:0] r;
    r = cur;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) r[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/instr_regbank_decode.sv
// rtl/instr_regbank_decode.sv - byte address to register index, range and read-only decode
module instr_regbank_decode
  import instr_regbank_pkg::*;
#(
  parameter int                  DW       = 32,
  parameter int                  AW       = 6,
  parameter int                  NUM_REGS = 8,
  parameter int                  IDX_W    = idx_width(NUM_REGS),
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic [AW-1:0]    addr,
  output logic [IDX_W-1:0] idx,
  output logic             oor,
  output logic             ro
);

  localparam int ADDR_LSB = $clog2(DW / 8);
  localparam int IDX_SPAN = 1 << IDX_W;

  logic [IDX_SPAN-1:0] ro_pad;
  logic [AW-1:0]       upper;

  assign ro_pad = IDX_SPAN'(RO_MASK);
  assign idx    = addr[ADDR_LSB +: IDX_W];
  assign upper  = addr >> (ADDR_LSB + IDX_W);
  assign oor    = (upper != '0) || ({1'b0, idx} >= (IDX_W + 1)'(NUM_REGS));
  // Register 0 is the doorbell and can never be made read-only.
  assign ro     = !oor && (idx != '0) && ro_pad[idx];

endmodule

// File: rtl/instr_regbank_axil.sv
// rtl/instr_regbank_axil.sv - AXI4-Lite register bank with status inputs and instruction doorbell
module instr_regbank_axil
  import instr_regbank_pkg::*;
#(
  parameter int                  C_S_AXI_DATA_WIDTH = 32,
  parameter int                  C_S_AXI_ADDR_WIDTH = 6,
  parameter int                  NUM_REGS           = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK            = '0
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
  input  logic [2:0]                         S_AXI_AWPROT,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ro_data,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic                               instr_valid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      instr_data,
  input  logic                               instr_ready
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int SW    = DW / 8;
  localparam int IDX_W = idx_width(NUM_REGS);

  logic [DW-1:0]    regs [NUM_REGS];
  logic             rst_done;
  logic             aw_full, w_full;
  logic [AW-1:0]    aw_addr_q;
  logic [DW-1:0]    w_data_q;
  logic [SW-1:0]    w_strb_q;

  logic             aw_hs, w_hs, ar_hs, wr_commit, wr_ok, db_hit, db_blocked, handshake_now;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data, wr_cur, wr_merged, rd_reg, rd_ro_val, rd_word;
  logic [SW-1:0]    wr_strb;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             wr_oor, wr_ro, rd_oor, rd_ro;
  logic             unused_prot;

  assign unused_prot   = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  assign S_AXI_AWREADY = rst_done && !aw_full && !S_AXI_BVALID;
  assign S_AXI_WREADY  = rst_done && !w_full && !S_AXI_BVALID;
  assign S_AXI_ARREADY = rst_done && !S_AXI_RVALID;
  assign aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs          = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

  // The buffered beat wins; otherwise the live beat is used so a same-cycle AW/W commits at once.
  assign wr_addr   = aw_full ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data   = w_full ? w_data_q : S_AXI_WDATA;
  assign wr_strb   = w_full ? w_strb_q : S_AXI_WSTRB;
  assign wr_commit = (aw_full || aw_hs) && (w_full || w_hs) && !S_AXI_BVALID;

  instr_regbank_decode #(
    .DW(DW), .AW(AW), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .RO_MASK(RO_MASK)
  ) u_wr_decode (
    .addr(wr_addr), .idx(wr_idx), .oor(wr_oor), .ro(wr_ro)
  );

  instr_regbank_decode #(
    .DW(DW), .AW(AW), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .RO_MASK(RO_MASK)
  ) u_rd_decode (
    .addr(S_AXI_ARADDR), .idx(rd_idx), .oor(rd_oor), .ro(rd_ro)
  );

  // A doorbell only blocks if it is still pending after this edge's downstream handshake.
  assign handshake_now = instr_valid && instr_ready;
  assign db_blocked    = instr_valid && !instr_ready;
  assign db_hit        = !wr_oor && (wr_idx == '0);
  assign wr_ok         = !wr_oor && !wr_ro && !(db_hit && db_blocked);
  assign wr_merged     = DW'(strb_merge(64'(wr_cur), 64'(wr_data), 8'(wr_strb)));

  always_comb begin
    wr_cur    = '0;
    rd_reg    = '0;
    rd_ro_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == IDX_W'(i)) wr_cur = regs[i];
      if (rd_idx == IDX_W'(i)) begin
        rd_reg    = regs[i];
        rd_ro_val = ro_data[i*DW +: DW];
      end
    end
    rd_word = rd_oor ? '0 : (rd_ro ? rd_ro_val : rd_reg);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rst_done     <= 1'b0;
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP  <= RESP_OKAY;
      S_AXI_RDATA  <= '0;
      instr_valid  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      rst_done <= 1'b1;
      if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
      if (wr_commit) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_full   <= 1'b1;
          aw_addr_q <= S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_full   <= 1'b1;
          w_data_q <= S_AXI_WDATA;
          w_strb_q <= S_AXI_WSTRB;
        end
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_commit && wr_ok && wr_idx == IDX_W'(i)) regs[i] <= wr_merged;
      end
      if (wr_commit && wr_ok && db_hit) instr_valid <= 1'b1;
      else if (handshake_now)          instr_valid <= 1'b0;
      if (S_AXI_RVALID && S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
      if (ar_hs) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_word;
        S_AXI_RRESP  <= rd_oor ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DW +: DW] = (g != 0 && RO_MASK[g]) ? '0 : regs[g];
  end

  assign instr_data = regs[0];

endmodule

// File: tb/tb_instr_regbank_axil.sv
// tb/tb_instr_regbank_axil.sv - directed self-checking bench for instr_regbank_axil
module tb_instr_regbank_axil;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [5:0]   awaddr = '0, araddr = '0;
  logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         awready, wready, bvalid, arready, rvalid, instr_valid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata, instr_data;
  logic [255:0] ro_data, reg_q;
  logic         instr_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [1:0]   resp;
  logic [31:0]  rd;

  always #5 clk = ~clk;

  instr_regbank_axil #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .NUM_REGS(8), .RO_MASK(8'h80)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ro_data(ro_data), .reg_q(reg_q),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // W is offered w_lead cycles ahead of AW; B is left unaccepted for b_hold cycles.
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, input int b_hold, output logic [1:0] r);
    logic aw_go, w_go;
    int n;
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int k = 0; k < w_lead; k++) begin
      w_go = wvalid && wready;
      @(negedge clk);
      if (w_go) wvalid = 1'b0;
    end
    awaddr = a; awvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(negedge clk);
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid  = 1'b0;
      n++;
    end
    if (n >= 20) chk("aw_w_timeout", 256'(n), 256'(0));
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid_latency", 256'(bvalid), 256'(1));
    r = bresp;
    for (int k = 0; k < b_hold; k++) begin
      chk("bp_awready", 256'(awready), 256'(0));
      chk("bp_wready",  256'(wready),  256'(0));
      chk("bp_bvalid",  256'(bvalid),  256'(1));
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ar_timeout", 256'(n), 256'(0));
    @(negedge clk);
    arvalid = 1'b0;
    chk("rvalid_latency", 256'(rvalid), 256'(1));
    d = rdata; r = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    ro_data = {32'hCAFEF00D, {7{32'hBADBAD00}}};
    #1;
    chk("rst_awready", 256'(awready), 256'(0));
    chk("rst_arready", 256'(arready), 256'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", 256'(awready), 256'(1));
    chk("post_rst_wready",  256'(wready),  256'(1));
    chk("post_rst_arready", 256'(arready), 256'(1));
    chk("post_rst_bvalid",  256'(bvalid),  256'(0));
    chk("post_rst_rvalid",  256'(rvalid),  256'(0));
    chk("post_rst_rdata",   256'(rdata),   256'(0));
    chk("post_rst_instr",   256'(instr_valid), 256'(0));
    chk("post_rst_reg_q",   reg_q, 256'(0));

    for (int i = 1; i <= 4; i++) begin
      axi_write(6'(i * 4), 32'(i), 4'hF, 0, 0, resp);
      chk("wr_resp", 256'(resp), 256'(0));
    end
    for (int i = 1; i <= 4; i++) begin
      axi_read(6'(i * 4), rd, resp);
      chk("rd_data", 256'(rd), 256'(i));
      chk("rd_resp", 256'(resp), 256'(0));
    end

    axi_write(6'h08, 32'h11223344, 4'hF, 0, 0, resp);
    axi_write(6'h08, 32'hAABBCCDD, 4'b0101, 3, 0, resp);
    chk("strb_resp", 256'(resp), 256'(0));
    axi_read(6'h08, rd, resp);
    chk("strb_data", 256'(rd), 256'(32'h11BB33DD));

    axi_write(6'h1C, 32'h12345678, 4'hF, 0, 0, resp);
    chk("ro_wr_resp", 256'(resp), 256'(2));
    chk("ro_wr_reg_q", reg_q, {32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h3, 32'h11BB33DD, 32'h1, 32'h0});
    axi_read(6'h1C, rd, resp);
    chk("ro_rd_data", 256'(rd), 256'(32'hCAFEF00D));
    chk("ro_rd_resp", 256'(resp), 256'(0));
    axi_write(6'h20, 32'h77777777, 4'hF, 0, 0, resp);
    chk("oor_wr_resp", 256'(resp), 256'(2));
    chk("oor_wr_reg_q", reg_q, {32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h3, 32'h11BB33DD, 32'h1, 32'h0});
    axi_read(6'h20, rd, resp);
    chk("oor_rd_data", 256'(rd), 256'(0));
    chk("oor_rd_resp", 256'(resp), 256'(2));

    axi_write(6'h00, 32'hDEAD0001, 4'hF, 0, 0, resp);
    chk("db_resp", 256'(resp), 256'(0));
    chk("db_valid", 256'(instr_valid), 256'(1));
    chk("db_data", 256'(instr_data), 256'(32'hDEAD0001));
    axi_write(6'h00, 32'h00000002, 4'hF, 0, 0, resp);
    chk("db_busy_resp", 256'(resp), 256'(2));
    chk("db_busy_data", 256'(instr_data), 256'(32'hDEAD0001));

    // Doorbell write on the same edge as the downstream handshake replaces the instruction.
    instr_ready = 1'b1;
    awaddr = 6'h00; awvalid = 1'b1; wdata = 32'h0000BEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("db_same_edge_bresp", 256'(bresp), 256'(0));
    chk("db_same_edge_valid", 256'(instr_valid), 256'(1));
    chk("db_same_edge_data",  256'(instr_data),  256'(32'h0000BEEF));
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("db_cleared", 256'(instr_valid), 256'(0));

    axi_write(6'h04, 32'd5, 4'hF, 0, 5, resp);
    chk("bp_resp", 256'(resp), 256'(0));

    awaddr = 6'h04; awvalid = 1'b1; wdata = 32'd9; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 6'h04; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("coll_rvalid", 256'(rvalid), 256'(1));
    chk("coll_bvalid", 256'(bvalid), 256'(1));
    chk("coll_rdata",  256'(rdata),  256'(5));
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    axi_read(6'h04, rd, resp);
    chk("coll_after", 256'(rd), 256'(9));

    axi_write(6'h00, 32'h12345678, 4'hF, 0, 0, resp);
    chk("pre_rst_instr", 256'(instr_valid), 256'(1));
    awaddr = 6'h0C; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_awready", 256'(awready), 256'(0));
    chk("mid_rst_bvalid",  256'(bvalid),  256'(0));
    chk("mid_rst_rdata",   256'(rdata),   256'(0));
    chk("mid_rst_instr",   256'(instr_valid), 256'(0));
    chk("mid_rst_reg_q",   reg_q, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    axi_write(6'h08, 32'h00000055, 4'hF, 2, 0, resp);
    chk("post_rst_wr_resp", 256'(resp), 256'(0));
    axi_read(6'h08, rd, resp);
    chk("post_rst_rd_data", 256'(rd), 256'(32'h55));
    chk("post_rst_reg3", 256'(reg_q[3*32 +: 32]), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
